// File: rtl/hazard_forward_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_forward_ctrl
//
// Hazard controller for the 5-stage MIPS pipeline. It sits beside ID and keeps
// shadow records of the instructions in EX and MEM. From those records it
// produces:
//   - registered EX-stage forwarding selects (0 = regfile, 1 = MEM ALU result,
//     2 = WB write data),
//   - same-cycle stall / bubble controls for load-use and MDU-busy hazards.
//
// Ports
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   ID_rs, ID_rt                source register numbers of the ID instruction
//   ID_uses_rs, ID_uses_rt      ID instruction actually reads that source
//   ID_dest, ID_reg_write       destination of the ID instruction / it writes it
//   ID_mem_read                 ID instruction is a load
//   ID_is_mdu, ID_mdu_read      ID instruction is mult/div, or mfhi/mflo
//   branch_flush                squash the ID instruction this cycle
//   Forward_in1_sel/in2_sel     registered forwarding selects for rs / rt
//   PC_write, IFID_write        low = hold PC and IF/ID
//   IDEX_flush                  insert a bubble into ID/EX
//   mdu_busy                    multiply/divide unit still busy
// -----------------------------------------------------------------------------
module hazard_forward_ctrl #(
    parameter int MDU_LATENCY = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_uses_rs,
    input  logic       ID_uses_rt,
    input  logic [4:0] ID_dest,
    input  logic       ID_reg_write,
    input  logic       ID_mem_read,
    input  logic       ID_is_mdu,
    input  logic       ID_mdu_read,
    input  logic       branch_flush,
    output logic [1:0] Forward_in1_sel,
    output logic [1:0] Forward_in2_sel,
    output logic       PC_write,
    output logic       IFID_write,
    output logic       IDEX_flush,
    output logic       mdu_busy
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MDU_WAIT   = 2'd2
    } state_t;

    // Stage records {valid, dest, reg_write, mem_read}
    logic       ex_valid_reg,     mem_valid_reg;
    logic [4:0] ex_dest_reg,      mem_dest_reg;
    logic       ex_reg_write_reg, mem_reg_write_reg;
    logic       ex_mem_read_reg;
    logic       mem_mem_read_reg;

    logic [5:0] mdu_cnt_reg, mdu_cnt_next;
    state_t     state_reg, state_next;

    logic       load_use_hazard;
    logic       mdu_hazard;
    logic       stall;
    logic       idex_flush_int;

    logic [4:0] src_num  [2];
    logic [1:0] src_uses;

    assign src_num[0] = ID_rs;
    assign src_num[1] = ID_rt;
    assign src_uses   = {ID_uses_rt, ID_uses_rs};

    // Per-source match and forwarding-select logic (index 0 = rs, 1 = rt).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic       ex_match;
            logic       mem_match;
            logic [1:0] fwd_next;
            logic [1:0] fwd_reg;

            // $0 is hardwired to zero, so it never matches a producer.
            assign ex_match  = ex_valid_reg & ex_reg_write_reg &
                               (ex_dest_reg == src_num[gi]) &
                               (src_num[gi] != 5'd0) & src_uses[gi];
            assign mem_match = mem_valid_reg & mem_reg_write_reg &
                               (mem_dest_reg == src_num[gi]) &
                               (src_num[gi] != 5'd0) & src_uses[gi];

            // Youngest producer wins; a bubbled instruction needs no forwarding.
            always_comb begin
                fwd_next = 2'd0;
                if (!idex_flush_int) begin
                    if (ex_match)
                        fwd_next = 2'd1;
                    else if (mem_match)
                        fwd_next = 2'd2;
                end
            end

            always_ff @(posedge clk) begin
                if (reset)
                    fwd_reg <= 2'd0;
                else
                    fwd_reg <= fwd_next;
            end
        end
    endgenerate

    assign Forward_in1_sel = g_src[0].fwd_reg;
    assign Forward_in2_sel = g_src[1].fwd_reg;

    // Hazard detection and pipeline controls (same-cycle combinational)
    assign load_use_hazard = (g_src[0].ex_match | g_src[1].ex_match) & ex_mem_read_reg;
    assign mdu_busy        = (mdu_cnt_reg != 6'd0);
    assign mdu_hazard      = mdu_busy & (ID_is_mdu | ID_mdu_read);
    // A squashed instruction cannot cause a hazard, so the flush overrides the stall.
    assign stall           = (load_use_hazard | mdu_hazard) & ~branch_flush;
    assign idex_flush_int  = stall | branch_flush;

    assign PC_write   = ~stall;
    assign IFID_write = ~stall;
    assign IDEX_flush = idex_flush_int;

    // Stage records: EX takes the ID instruction or a bubble, MEM follows EX.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_reg      <= 1'b0;
            ex_dest_reg       <= 5'd0;
            ex_reg_write_reg  <= 1'b0;
            ex_mem_read_reg   <= 1'b0;
            mem_valid_reg     <= 1'b0;
            mem_dest_reg      <= 5'd0;
            mem_reg_write_reg <= 1'b0;
            mem_mem_read_reg  <= 1'b0;
        end else begin
            mem_valid_reg     <= ex_valid_reg;
            mem_dest_reg      <= ex_dest_reg;
            mem_reg_write_reg <= ex_reg_write_reg;
            mem_mem_read_reg  <= ex_mem_read_reg;
            if (idex_flush_int) begin
                ex_valid_reg     <= 1'b0;
                ex_dest_reg      <= 5'd0;
                ex_reg_write_reg <= 1'b0;
                ex_mem_read_reg  <= 1'b0;
            end else begin
                ex_valid_reg     <= 1'b1;
                ex_dest_reg      <= ID_dest;
                ex_reg_write_reg <= ID_reg_write;
                ex_mem_read_reg  <= ID_mem_read;
            end
        end
    end

    // MDU busy counter: reload when an MDU op actually enters EX.
    always_comb begin
        mdu_cnt_next = mdu_cnt_reg;
        if (ID_is_mdu && !idex_flush_int)
            mdu_cnt_next = 6'(MDU_LATENCY);
        else if (mdu_cnt_reg != 6'd0)
            mdu_cnt_next = mdu_cnt_reg - 6'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            mdu_cnt_reg <= 6'd0;
        else
            mdu_cnt_reg <= mdu_cnt_next;
    end

    // Stall-cause tracker, kept for debug visibility; outputs do not use it.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (mdu_hazard)
                    state_next = ST_MDU_WAIT;
                else if (load_use_hazard)
                    state_next = ST_LOAD_STALL;
            end
            ST_LOAD_STALL: state_next = ST_IDLE;
            ST_MDU_WAIT: begin
                if (!mdu_hazard)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_forward_ctrl
//
// Directed-vector bench for hazard_forward_ctrl with MDU_LATENCY = 4. Each
// scenario task drives ID-stage instructions, compares the outputs against
// hand-computed values and prints one line per transaction.
// -----------------------------------------------------------------------------
module tb_hazard_forward_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] ID_rs, ID_rt, ID_dest;
    logic       ID_uses_rs, ID_uses_rt, ID_reg_write, ID_mem_read;
    logic       ID_is_mdu, ID_mdu_read, branch_flush;
    logic [1:0] Forward_in1_sel, Forward_in2_sel;
    logic       PC_write, IFID_write, IDEX_flush, mdu_busy;

    int vec_count = 0;
    int err_count = 0;

    hazard_forward_ctrl #(.MDU_LATENCY(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .ID_rs           (ID_rs),
        .ID_rt           (ID_rt),
        .ID_uses_rs      (ID_uses_rs),
        .ID_uses_rt      (ID_uses_rt),
        .ID_dest         (ID_dest),
        .ID_reg_write    (ID_reg_write),
        .ID_mem_read     (ID_mem_read),
        .ID_is_mdu       (ID_is_mdu),
        .ID_mdu_read     (ID_mdu_read),
        .branch_flush    (branch_flush),
        .Forward_in1_sel (Forward_in1_sel),
        .Forward_in2_sel (Forward_in2_sel),
        .PC_write        (PC_write),
        .IFID_write      (IFID_write),
        .IDEX_flush      (IDEX_flush),
        .mdu_busy        (mdu_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt,
                          input logic [4:0] dest, input logic rw, input logic mr,
                          input logic mdu, input logic mdurd);
        ID_rs        = rs;
        ID_rt        = rt;
        ID_uses_rs   = urs;
        ID_uses_rt   = urt;
        ID_dest      = dest;
        ID_reg_write = rw;
        ID_mem_read  = mr;
        ID_is_mdu    = mdu;
        ID_mdu_read  = mdurd;
    endtask

    task automatic set_nop();
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Push enough nops to empty the records and let the MDU counter expire.
    task automatic drain();
        set_nop();
        branch_flush = 1'b0;
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_reset();
        set_nop();
        branch_flush = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        settle();
        vec_count++;
        if (Forward_in1_sel !== 2'd0 || Forward_in2_sel !== 2'd0 || mdu_busy !== 1'b0 ||
            PC_write !== 1'b1 || IFID_write !== 1'b1 || IDEX_flush !== 1'b0) begin
            err_count++;
            $display("FAIL reset_values: sel1=%0d sel2=%0d busy=%0b pcw=%0b ifid=%0b flush=%0b, want 0 0 0 1 1 0",
                     Forward_in1_sel, Forward_in2_sel, mdu_busy, PC_write, IFID_write, IDEX_flush);
        end else
            $display("reset_values ok");
    endtask

    task automatic test_fwd_ex();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);   // add r3,r1,r2
        tick();
        set_id(5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);   // sub r4,r3,r5
        settle();
        vec_count++;
        if (PC_write !== 1'b1 || IDEX_flush !== 1'b0) begin
            err_count++;
            $display("FAIL fwd_ex_nostall: pcw=%0b flush=%0b, want 1 0", PC_write, IDEX_flush);
        end else
            $display("fwd_ex_nostall ok");
        tick();
        set_nop();
        settle();
        vec_count++;
        if (Forward_in1_sel !== 2'd1 || Forward_in2_sel !== 2'd0) begin
            err_count++;
            $display("FAIL fwd_ex_sel: sel1=%0d sel2=%0d, want 1 0", Forward_in1_sel, Forward_in2_sel);
        end else
            $display("fwd_ex_sel ok");
        drain();
    endtask

    task automatic test_fwd_mem();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);   // add r3
        tick();
        set_nop();
        tick();
        set_id(5'd2, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);   // or r6,r2,r3
        settle();
        vec_count++;
        if (PC_write !== 1'b1) begin
            err_count++;
            $display("FAIL fwd_mem_nostall: pcw=%0b, want 1", PC_write);
        end else
            $display("fwd_mem_nostall ok");
        tick();
        set_nop();
        settle();
        vec_count++;
        if (Forward_in1_sel !== 2'd0 || Forward_in2_sel !== 2'd2) begin
            err_count++;
            $display("FAIL fwd_mem_sel: sel1=%0d sel2=%0d, want 0 2", Forward_in1_sel, Forward_in2_sel);
        end else
            $display("fwd_mem_sel ok");
        drain();
    endtask

    task automatic test_load_use();
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);   // lw r7
        tick();
        set_id(5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);   // add r8,r7,r7
        settle();
        vec_count++;
        if (PC_write !== 1'b0 || IFID_write !== 1'b0 || IDEX_flush !== 1'b1) begin
            err_count++;
            $display("FAIL load_use_stall: pcw=%0b ifid=%0b flush=%0b, want 0 0 1", PC_write, IFID_write, IDEX_flush);
        end else
            $display("load_use_stall ok");
        tick();   // add is held in ID, bubble enters EX
        vec_count++;
        if (PC_write !== 1'b1 || IDEX_flush !== 1'b0 || Forward_in1_sel !== 2'd0 || Forward_in2_sel !== 2'd0) begin
            err_count++;
            $display("FAIL load_use_one_cycle: pcw=%0b flush=%0b sel1=%0d sel2=%0d, want 1 0 0 0",
                     PC_write, IDEX_flush, Forward_in1_sel, Forward_in2_sel);
        end else
            $display("load_use_one_cycle ok");
        tick();
        set_nop();
        settle();
        vec_count++;
        if (Forward_in1_sel !== 2'd2 || Forward_in2_sel !== 2'd2) begin
            err_count++;
            $display("FAIL load_use_sel: sel1=%0d sel2=%0d, want 2 2", Forward_in1_sel, Forward_in2_sel);
        end else
            $display("load_use_sel ok");
        drain();
    endtask

    task automatic test_priority_r0();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);   // add r9
        tick();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);   // add r9 again
        tick();
        set_id(5'd9, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);  // reader of r9
        tick();
        set_nop();
        settle();
        vec_count++;
        if (Forward_in1_sel !== 2'd1 || Forward_in2_sel !== 2'd1) begin
            err_count++;
            $display("FAIL priority_sel: sel1=%0d sel2=%0d, want 1 1", Forward_in1_sel, Forward_in2_sel);
        end else
            $display("priority_sel ok");
        drain();
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);   // lw r0
        tick();
        set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);  // reader of r0
        settle();
        vec_count++;
        if (PC_write !== 1'b1 || IDEX_flush !== 1'b0) begin
            err_count++;
            $display("FAIL r0_nostall: pcw=%0b flush=%0b, want 1 0", PC_write, IDEX_flush);
        end else
            $display("r0_nostall ok");
        tick();
        set_nop();
        settle();
        vec_count++;
        if (Forward_in1_sel !== 2'd0 || Forward_in2_sel !== 2'd0) begin
            err_count++;
            $display("FAIL r0_sel: sel1=%0d sel2=%0d, want 0 0", Forward_in1_sel, Forward_in2_sel);
        end else
            $display("r0_sel ok");
        drain();
    endtask

    task automatic test_mdu();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);   // div
        tick();
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1);  // mflo r12
        settle();
        for (int i = 0; i < 4; i++) begin
            vec_count++;
            if (PC_write !== 1'b0 || IDEX_flush !== 1'b1 || mdu_busy !== 1'b1) begin
                err_count++;
                $display("FAIL mdu_stall_%0d: pcw=%0b flush=%0b busy=%0b, want 0 1 1", i, PC_write, IDEX_flush, mdu_busy);
            end else
                $display("mdu_stall_%0d ok", i);
            tick();
            settle();
        end
        vec_count++;
        if (mdu_busy !== 1'b0 || PC_write !== 1'b1 || IDEX_flush !== 1'b0) begin
            err_count++;
            $display("FAIL mdu_release: busy=%0b pcw=%0b flush=%0b, want 0 1 0", mdu_busy, PC_write, IDEX_flush);
        end else
            $display("mdu_release ok");
        drain();
    endtask

    task automatic test_mdu_reset();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);   // div
        tick();
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1);  // mflo
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        vec_count++;
        if (mdu_busy !== 1'b0 || PC_write !== 1'b1 || IDEX_flush !== 1'b0) begin
            err_count++;
            $display("FAIL mdu_reset: busy=%0b pcw=%0b flush=%0b, want 0 1 0", mdu_busy, PC_write, IDEX_flush);
        end else
            $display("mdu_reset ok");
        drain();
    endtask

    task automatic test_back_to_back();
        int n;
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);   // mult
        tick();
        set_id(5'd3, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);   // div, back-to-back
        settle();
        n = 0;
        while (PC_write !== 1'b1 && n < 20) begin
            n++;
            tick();
            settle();
        end
        vec_count++;
        if (n != 4) begin
            err_count++;
            $display("FAIL b2b_stall_cycles: got %0d, want 4", n);
        end else
            $display("b2b_stall_cycles ok");
        tick();   // second op enters EX and reloads the counter
        set_nop();
        settle();
        vec_count++;
        if (mdu_busy !== 1'b1) begin
            err_count++;
            $display("FAIL b2b_reload: busy=%0b, want 1", mdu_busy);
        end else
            $display("b2b_reload ok");
        drain();
    endtask

    task automatic test_flush_hazard();
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);   // lw r7
        tick();
        set_id(5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);   // add r8,r7,r7
        branch_flush = 1'b1;
        settle();
        vec_count++;
        if (PC_write !== 1'b1 || IFID_write !== 1'b1 || IDEX_flush !== 1'b1) begin
            err_count++;
            $display("FAIL flush_load_ctrl: pcw=%0b ifid=%0b flush=%0b, want 1 1 1", PC_write, IFID_write, IDEX_flush);
        end else
            $display("flush_load_ctrl ok");
        tick();
        branch_flush = 1'b0;
        set_nop();
        settle();
        vec_count++;
        if (Forward_in1_sel !== 2'd0 || Forward_in2_sel !== 2'd0) begin
            err_count++;
            $display("FAIL flush_load_sel: sel1=%0d sel2=%0d, want 0 0", Forward_in1_sel, Forward_in2_sel);
        end else
            $display("flush_load_sel ok");
        drain();
        set_id(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);   // div squashed
        branch_flush = 1'b1;
        tick();
        branch_flush = 1'b0;
        set_nop();
        settle();
        vec_count++;
        if (mdu_busy !== 1'b0) begin
            err_count++;
            $display("FAIL flush_mdu_noload: busy=%0b, want 0", mdu_busy);
        end else
            $display("flush_mdu_noload ok");
        drain();
    endtask

    initial begin
        reset        = 1'b1;
        branch_flush = 1'b0;
        set_nop();
        test_reset();
        test_fwd_ex();
        test_fwd_mem();
        test_load_use();
        test_priority_r0();
        test_mdu();
        test_mdu_reset();
        test_back_to_back();
        test_flush_hazard();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
